mem_burst_ctrl: RTL

Burst request controller sitting directly upstream of the 2048×16 memory block. It accepts one command (start address, beat count, read/write) and streams write data in or read data out. It converts the command into single-beat valid/write/addr/wdata accesses on the memory port, checks addresses and memory error, and reports completion.

---
 rtl/mem_burst_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: turns one burst command into single-beat memory accesses
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write, cmd_addr, cmd_len   burst command (beats = cmd_len+1)
//   wr_valid/ready, wr_data  write-data stream in
//   rd_valid/ready, rd_data  read-data stream out
//   mem_valid, mem_write, mem_addr, mem_wdata       memory request
//   mem_ready, mem_error, mem_rdata                 memory response
//   busy, done, err          status: not idle, end-of-command pulse, sticky error
module mem_burst_ctrl #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int LW       = 8,
    parameter int MAX_ADDR = 2047,
    parameter int WD_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          mem_valid,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_error,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int WW = $clog2(WD_LIMIT + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_ADDR);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_LIMIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t state, state_nx;
    logic [AW-1:0] addr;
    logic [LW-1:0] cnt;
    logic [WW-1:0] wd;
    logic wr_flag, over, issue, step, last, timeout;

    // an out-of-range beat aborts in ISSUE, so a wrapped address is never issued
    assign over    = addr > LAST_ADDR;
    assign issue   = state == S_ISSUE && !over && (!wr_flag || wr_valid);
    assign step    = (state == S_WAIT && mem_ready && !mem_error && wr_flag) || (state == S_HOLD && rd_ready);
    assign last    = cnt == '0;
    assign timeout = state == S_WAIT && !mem_ready && wd == WD_LAST;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = cmd_valid ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nx = over ? S_DONE : issue ? S_WAIT : S_ISSUE;
            S_WAIT:  state_nx = mem_ready ? ((mem_error || (wr_flag && last)) ? S_DONE : wr_flag ? S_ISSUE : S_HOLD)
                              : timeout ? S_DONE : S_WAIT;
            S_HOLD:  state_nx = rd_ready ? (last ? S_DONE : S_ISSUE) : S_HOLD;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = state == S_IDLE;
        wr_ready  = state == S_ISSUE && wr_flag && !over;
        busy      = state != S_IDLE;
        done      = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            cnt       <= '0;
            wr_flag   <= 1'b0;
            wd        <= '0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            mem_valid <= issue;
            if (issue) begin
                mem_write <= wr_flag;
                mem_addr  <= addr;
                if (wr_flag) mem_wdata <= wr_data;
            end
            if (state == S_IDLE && cmd_valid) begin
                addr    <= cmd_addr;
                cnt     <= cmd_len;
                wr_flag <= cmd_write;
                err     <= 1'b0;
            end
            if ((state == S_ISSUE && over) || (state == S_WAIT && mem_ready && mem_error) || timeout) err <= 1'b1;
            // watchdog counts every WAIT cycle, including the one with mem_valid high
            wd <= state == S_WAIT ? wd + WW'(1) : '0;
            if (state == S_WAIT && mem_ready && !mem_error && !wr_flag) begin
                rd_data  <= mem_rdata;
                rd_valid <= 1'b1;
            end
            if (state == S_HOLD && rd_ready) rd_valid <= 1'b0;
            if (step && !last) begin
                addr <= addr + AW'(1);
                cnt  <= cnt - LW'(1);
            end
        end
    end
endmodule
